// File: rtl/apb_slv_pkg.sv
// Shared types and constants for the APB register-bank completer.
package apb_slv_pkg;

  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned WAIT_W     = 4;
  localparam int unsigned LFSR_W     = 16;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as state bits 15,13,12,10.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef logic [APB_DATA_W-1:0] word_t;

endpackage

// File: rtl/apb_slv_lfsr.sv
// 16-bit Fibonacci LFSR stepped once per enable; exposes the low nibble
// used to randomise the wait-state count.
module apb_slv_lfsr
  import apb_slv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [WAIT_W-1:0] value
);

  logic [LFSR_W-1:0] lfsr;

  // Shift left, feeding back the XOR of the tapped bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (en) begin
      lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  assign value = lfsr[WAIT_W-1:0];

endmodule

// File: rtl/apb_slave_responder.sv
// APB3 completer with a word-addressed register bank, programmable wait
// states and PSLVERR on misaligned / out-of-range accesses.
// Optional: define APB_SLV_LFSR_WAIT_EN to mask the wait count with an LFSR.
module apb_slave_responder
  import apb_slv_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       NUM_REGS    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int unsigned       IDX_W     = $clog2(NUM_REGS);
  localparam logic [ADDR_W-3:0] REG_LIMIT = (ADDR_W-2)'(NUM_REGS);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q;
  logic              write_q;
  logic              err_q;
  logic [DATA_W-1:0] wdata_q;
  word_t             regs [NUM_REGS];

  logic [ADDR_W-1:0] off_c;
  logic              err_c;
  logic [WAIT_W-1:0] load_c;
  logic              setup_c;
  logic              commit_c;
  logic              pready_d;
  logic              pslverr_d;
  logic [DATA_W-1:0] prdata_d;

  // Address decode of the setup-phase address.
  always_comb begin
    off_c = paddr - BASE_ADDR;
    err_c = (paddr < BASE_ADDR) || (off_c[1:0] != 2'b00) ||
            (off_c[ADDR_W-1:2] >= REG_LIMIT);
  end

`ifdef APB_SLV_LFSR_WAIT_EN
  logic [WAIT_W-1:0] lfsr_nib;

  apb_slv_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (setup_c),
    .value (lfsr_nib)
  );

  assign load_c = lfsr_nib & WAIT_LOAD;
`else
  assign load_c = WAIT_LOAD;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and next registered response.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    setup_c   = 1'b0;
    commit_c  = 1'b0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          setup_c = 1'b1;
          cnt_d   = load_c;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (penable) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - WAIT_W'(1);
          end else begin
            state_d   = DONE;
            pready_d  = 1'b1;
            pslverr_d = err_q;
            if (!err_q && !write_q) prdata_d = DATA_W'(regs[idx_q]);
          end
        end
      end
      DONE: begin
        commit_c = write_q && !err_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Wait counter, latched setup phase and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      pready  <= pready_d;
      pslverr <= pslverr_d;
      prdata  <= prdata_d;
      if (setup_c) begin
        idx_q   <= off_c[IDX_W+1:2];
        write_q <= pwrite;
        err_q   <= err_c;
        wdata_q <= pwdata;
      end
    end
  end

  // Register bank; writes commit during the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit_c) begin
      regs[idx_q] <= APB_DATA_W'(wdata_q);
    end
  end

endmodule

// File: tb/tb_apb_slave_responder.sv
// Directed bench for apb_slave_responder: three instances with different wait
// configurations, a vector table plus hand sequences for abort and reset.
module tb_apb_slave_responder;

  localparam int unsigned NDUT = 3;
  localparam int unsigned WC0  = 0;
`ifdef APB_SLV_LFSR_WAIT_EN
  localparam int unsigned WC1  = 15;
`else
  localparam int unsigned WC1  = 3;
`endif
  localparam int unsigned WC2  = 2;

  logic        clk;
  logic        rst_n;
  logic        psel    [NDUT];
  logic        penable [NDUT];
  logic        pwrite  [NDUT];
  logic [31:0] paddr   [NDUT];
  logic [31:0] pwdata  [NDUT];
  logic [31:0] prdata  [NDUT];
  logic        pready  [NDUT];
  logic        pslverr [NDUT];

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    apb_slave_responder #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .NUM_REGS    (16),
      .BASE_ADDR   (32'h0000_1000),
      .WAIT_CYCLES (g == 0 ? WC0 : (g == 1 ? WC1 : WC2))
    ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .psel    (psel[g]),
      .penable (penable[g]),
      .pwrite  (pwrite[g]),
      .paddr   (paddr[g]),
      .pwdata  (pwdata[g]),
      .prdata  (prdata[g]),
      .pready  (pready[g]),
      .pslverr (pslverr[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic int unsigned wc_of(input int d);
    case (d)
      0:       return WC0;
      1:       return WC1;
      default: return WC2;
    endcase
  endfunction

`ifdef APB_SLV_LFSR_WAIT_EN
  logic [15:0] m_lfsr [NDUT];
`endif

  task automatic model_reset();
`ifdef APB_SLV_LFSR_WAIT_EN
    for (int i = 0; i < NDUT; i++) m_lfsr[i] = 16'hACE1;
`endif
  endtask

  // Expected number of access-phase samples up to and including pready=1.
  task automatic next_acc(input int d, output int acc);
`ifdef APB_SLV_LFSR_WAIT_EN
    logic [15:0] l;
    l = m_lfsr[d];
    acc = int'(l[3:0] & 4'(wc_of(d))) + 2;
    m_lfsr[d] = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
`else
    acc = int'(wc_of(d)) + 2;
`endif
  endtask

  task automatic check(input string tag, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h required %h", tag, what, act, exp);
    end
  endtask

  // One APB transfer; access-phase address/data are scrambled to prove latching.
  task automatic xfer(input int d, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic exp_err,
                      input logic [31:0] exp_rd, input string tag);
    int   acc;
    int   exp_acc;
    logic clean;
    next_acc(d, exp_acc);
    @(negedge clk);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = a; pwdata[d] = wd;
    @(negedge clk);
    penable[d] = 1'b1; paddr[d] = ~a; pwdata[d] = ~wd;
    acc = 0;
    clean = 1'b1;
    while (1) begin
      acc++;
      if (pready[d]) break;
      if (prdata[d] !== 32'h0 || pslverr[d] !== 1'b0) clean = 1'b0;
      if (acc > 40) break;
      @(negedge clk);
    end
    check(tag, "access_cycles", 32'(acc), 32'(exp_acc));
    check(tag, "quiet_while_waiting", 32'(clean), 32'd1);
    check(tag, "pslverr", 32'(pslverr[d]), 32'(exp_err));
    if (!wr || exp_err) check(tag, "prdata", prdata[d], exp_rd);
  endtask

  // Setup a write, then drop psel on the first access cycle.
  task automatic abort_write(input int d, input logic [31:0] a, input logic [31:0] wd);
    int   dummy;
    logic seen;
    next_acc(d, dummy);
    @(negedge clk);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = 1'b1;
    paddr[d] = a; pwdata[d] = wd;
    @(negedge clk);
    psel[d] = 1'b0; penable[d] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (pready[d]) seen = 1'b1;
    end
    check("abort", "pready_pulse", 32'(seen), 32'd0);
  endtask

  typedef struct {
    int          dut;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    string       tag;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int dummy;

    vecs[0]  = '{0, 1'b1, 32'h0000_1008, 32'hDEAD_BEEF, 1'b0, 32'h0,          "wr_1008"};
    vecs[1]  = '{0, 1'b0, 32'h0000_1008, 32'h0,         1'b0, 32'hDEAD_BEEF, "rd_1008"};
    vecs[2]  = '{0, 1'b1, 32'h0000_1000, 32'h1234_5678, 1'b0, 32'h0,          "wr_1000"};
    vecs[3]  = '{0, 1'b1, 32'h0000_1040, 32'hCAFE_0001, 1'b1, 32'h0,          "wr_range"};
    vecs[4]  = '{0, 1'b1, 32'h0000_1002, 32'hCAFE_0002, 1'b1, 32'h0,          "wr_misalign"};
    vecs[5]  = '{0, 1'b0, 32'h0000_1000, 32'h0,         1'b0, 32'h1234_5678, "rd_unchanged"};
    vecs[6]  = '{0, 1'b0, 32'h0000_0FFC, 32'h0,         1'b1, 32'h0,          "rd_below_base"};
    vecs[7]  = '{0, 1'b1, 32'h0000_103C, 32'hA5A5_A5A5, 1'b0, 32'h0,          "wr_last"};
    vecs[8]  = '{0, 1'b0, 32'h0000_103C, 32'h0,         1'b0, 32'hA5A5_A5A5, "rd_last"};
    vecs[9]  = '{0, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0,          "rd_top"};
    vecs[10] = '{1, 1'b0, 32'h0000_1000, 32'h0,         1'b0, 32'h0,          "rd_wait"};
    vecs[11] = '{2, 1'b1, 32'h0000_1004, 32'h1111_1111, 1'b0, 32'h0,          "wr_pre_abort"};
    vecs[12] = '{1, 1'b0, 32'h0000_1040, 32'h0,         1'b1, 32'h0,          "rd_err_wait"};

    rst_n = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
      paddr[i] = '0; pwdata[i] = '0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      check("reset", "pready", 32'(pready[i]), 32'd0);
      check("reset", "pslverr", 32'(pslverr[i]), 32'd0);
      check("reset", "prdata", prdata[i], 32'h0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      xfer(vecs[i].dut, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
           vecs[i].err, vecs[i].rdata, vecs[i].tag);
    end

    abort_write(2, 32'h0000_1004, 32'h5555_5555);
    xfer(2, 1'b0, 32'h0000_1004, 32'h0, 1'b0, 32'h1111_1111, "rd_after_abort");

    // Back-to-back writes then reads with no idle cycle between transfers.
    for (int i = 0; i < 8; i++)
      xfer(0, 1'b1, 32'h0000_1000 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 1'b0, 32'h0, "b2b_wr");
    for (int i = 0; i < 8; i++)
      xfer(0, 1'b0, 32'h0000_1000 + 32'(4 * i), 32'h0, 1'b0, 32'hC0DE_0000 + 32'(i), "b2b_rd");

    // Reset while dut1 waits on a write and dut0 is presenting a read response.
    next_acc(1, dummy);
    @(negedge clk);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'h0000_1000; pwdata[1] = 32'h7777_7777;
    @(negedge clk);
    penable[1] = 1'b1;
    xfer(0, 1'b0, 32'h0000_1008, 32'h0, 1'b0, 32'hC0DE_0002, "rd_before_reset");
    #1 rst_n = 1'b0;
    #1;
    check("async_reset", "dut0_pready", 32'(pready[0]), 32'd0);
    check("async_reset", "dut0_pslverr", 32'(pslverr[0]), 32'd0);
    check("async_reset", "dut0_prdata", prdata[0], 32'h0);
    check("async_reset", "dut1_pready", 32'(pready[1]), 32'd0);
    model_reset();
    for (int i = 0; i < NDUT; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    xfer(1, 1'b0, 32'h0000_1000, 32'h0, 1'b0, 32'h0, "rd_lost_write");
    xfer(0, 1'b0, 32'h0000_1008, 32'h0, 1'b0, 32'h0, "rd_cleared_1008");
    xfer(0, 1'b0, 32'h0000_101C, 32'h0, 1'b0, 32'h0, "rd_cleared_101c");

    // Wait-count sequence on dut1 (fixed, or LFSR-masked when enabled).
    for (int i = 0; i < 4; i++)
      xfer(1, 1'b1, 32'h0000_1000 + 32'(4 * i), 32'hF00D_0000 + 32'(i), 1'b0, 32'h0, "seq_wr");
    for (int i = 0; i < 16; i++)
      xfer(1, 1'b0, 32'h0000_1000 + 32'(4 * (i % 4)), 32'h0, 1'b0,
           32'hF00D_0000 + 32'(i % 4), "seq_rd");

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_slave_responder.md
Name: apb_slave_responder

Overview:
- APB3 completer that terminates one APB master port of the ICB-to-APB bridge; one instance per apb_bus_0..3.
- Holds a word-addressed 32-bit register bank at BASE_ADDR and responds to reads and writes.
- Inserts programmable wait states.
- Flags misaligned and out-of-range accesses with PSLVERR, so the bridge's error and stall paths are exercised in the UVM bench and usable as a simple peripheral in the full design.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width (fixed at 32; other values are not supported).
- NUM_REGS, 16, number of 32-bit registers in the bank (power of two, 2..256).
- BASE_ADDR, 32'h0000_0000, byte address of register 0.
- WAIT_CYCLES, 0, extra access-phase cycles before PREADY (0..15).

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- psel  in  1  APB select.
- penable  in  1  APB enable (access phase).
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  byte address.
- pwdata  in  DATA_W  write data.
- prdata  out  DATA_W  read data, valid only when pready=1.
- pready  out  1  transfer complete.
- pslverr  out  1  error response, valid only when pready=1.

Behaviour:
- Reset (async assert, sync deassert by the bench): state=IDLE, pready=0, pslverr=0, prdata=0, all registers=0, wait counter=0.
- FSM states:
  - IDLE: on psel=1 & penable=0 (setup phase), latch paddr, pwrite and pwdata; compute err; load wait counter with WAIT_CYCLES; go to ACCESS.
  - ACCESS: psel=1 & penable=1 and counter>0: decrement; pready=0.
  - ACCESS: psel=1 & penable=1 and counter=0: go to DONE with registered pready=1 next cycle.
  - DONE: pready=1 for exactly one cycle. Writes commit in this cycle if err=0. Return to IDLE.
- Response registration: pready, pslverr and prdata are all registered. With WAIT_CYCLES=0, pready rises on the 2nd access-phase cycle (one mandatory wait); total transfer = setup + (WAIT_CYCLES+2) access cycles.
- Back-to-back: a setup phase arriving on the cycle after DONE is accepted normally (IDLE samples it).
- Address decode: off = paddr - BASE_ADDR (ADDR_W-bit unsigned subtraction).
- err=1 if any of:
  - paddr < BASE_ADDR
  - off[1:0] != 0
  - off[ADDR_W-1:2] >= NUM_REGS
- Error response: pslverr=1 with pready; write suppressed; prdata=0.
- Read response: prdata = reg[off index] in DONE; prdata=0 in every cycle where pready=0.
- Latched phase: paddr, pwrite and pwdata are taken from the setup phase only; changes during the access phase are ignored.
- psel dropping to 0 in ACCESS (protocol abort): return to IDLE next cycle, no write, no pready pulse.
- penable=1 while in IDLE: ignored.
- Async reset mid-transfer: immediate return to reset values. A partially waited write is lost.

Optional Feature:
- Macro APB_SLV_LFSR_WAIT_EN.
- Defined:
  - The wait counter load value is lfsr[3:0] & WAIT_CYCLES[3:0] instead of WAIT_CYCLES.
  - lfsr is a 16-bit Fibonacci LFSR, taps 16,14,13,11, reset seed 16'hACE1, advanced once per accepted setup phase.
  - Gives a deterministic, varying stall pattern per transfer.
- Undefined: fixed WAIT_CYCLES wait; no LFSR logic is synthesised.

Decomposition:
- Package apb_slv_pkg:
  - state enum (IDLE, ACCESS, DONE)
  - APB_DATA_W=32
  - LFSR_SEED=16'hACE1
  - LFSR tap mask
- Sub-module apb_slv_lfsr: 16-bit LFSR with enable and async reset. Instantiated only under APB_SLV_LFSR_WAIT_EN.

Test Plan:
- Write/read, WAIT_CYCLES=0, BASE_ADDR=32'h1000:
  - write 32'hDEAD_BEEF to 32'h1008 -> pready on 2nd access cycle, pslverr=0.
  - read 32'h1008 -> prdata=32'hDEAD_BEEF.
- Wait states, WAIT_CYCLES=3: read of 32'h1000 after reset -> pready low for 4 access cycles, high on 5th, prdata=0.
- Errors, NUM_REGS=16:
  - write 32'h1040 -> pslverr=1, pready=1.
  - write 32'h1002 -> pslverr=1.
  - subsequent read 32'h1000 -> unchanged value, pslverr=0.
  - address 32'h0FFC -> pslverr=1.
- Abort: setup write 32'h5555_5555 to 32'h1004, drop psel on 1st access cycle (WAIT_CYCLES=2) -> no pready pulse; read 32'h1004 returns prior value.
- Back-to-back plus reset:
  - 8 consecutive writes 32'h1000..32'h101C then 8 reads -> data match, no idle gap required.
  - assert rst_n=0 mid-wait -> pready=0, pslverr=0, prdata=0 immediately; all regs read 0 after release.
- APB_SLV_LFSR_WAIT_EN with WAIT_CYCLES=15: 16 reads -> wait count per transfer equals lfsr[3:0] sequence from seed 16'hACE1; data correct on every transfer.
